// File: rtl/fli_pkg.sv
// Shared constants for the fluid level monitor: register map, event bits and
// a constant clog2 used to size the level and counter fields.
package fli_pkg;

  localparam logic [1:0] REG_LVL = 2'd0;
  localparam logic [1:0] REG_IER = 2'd1;
  localparam logic [1:0] REG_IFR = 2'd2;
  localparam logic [1:0] REG_THR = 2'd3;

  localparam int EVT_FULL  = 0;
  localparam int EVT_EMPTY = 1;
  localparam int EVT_ERROR = 2;
  localparam int EVT_HIGH  = 3;
  localparam int EVT_LOW   = 4;
  localparam int NUM_EVT   = 5;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/fli_sample_debounce.sv
// Tick generator plus sensor debouncer: a sample is accepted once DEBOUNCE
// consecutive ticks have seen the same value.
module fli_sample_debounce
  import fli_pkg::*;
#(
  parameter int SENSOR_BITS = 8,
  parameter int CLK_DIV     = 9999999,
  parameter int DEBOUNCE    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SENSOR_BITS-1:0] sensor_in,
  output logic [SENSOR_BITS-1:0] stable,
  output logic                   stable_valid
);

  localparam int DIVW = (CLK_DIV == 0) ? 1 : clog2(CLK_DIV + 1);
  localparam int CW   = clog2(DEBOUNCE + 1);

  logic [DIVW-1:0]        div_q, div_d;
  logic                   tick;
  logic [SENSOR_BITS-1:0] cand_q, cand_d, stable_q, stable_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   valid_q, valid_d;

  assign tick  = (div_q == '0);
  assign div_d = tick ? DIVW'(CLK_DIV) : div_q - DIVW'(1);

  // stable is loaded on the same tick that completes the run, so it is
  // visible the cycle after that tick.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    valid_d  = valid_q;
    if (tick) begin
      if (sensor_in != cand_q) begin
        cand_d = sensor_in;
        cnt_d  = CW'(1);
      end else if (cnt_q != CW'(DEBOUNCE)) begin
        cnt_d = cnt_q + CW'(1);
      end
      if (cnt_d == CW'(DEBOUNCE)) begin
        stable_d = cand_d;
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= DIVW'(CLK_DIV);
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      div_q    <= div_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      valid_q  <= valid_d;
    end
  end

  assign stable       = stable_q;
  assign stable_valid = valid_q;

endmodule

// File: rtl/fluid_level_monitor.sv
// Tank level peripheral: debounced thermometer sensors, level/error decode,
// edge-detected events into a W1C flag register and a maskable level irq.
module fluid_level_monitor
  import fli_pkg::*;
#(
  parameter int SENSOR_BITS = 8,
  parameter int CLK_DIV     = 9999999,
  parameter int DEBOUNCE    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             wr_addr,
  input  logic                   wr_en,
  input  logic [31:0]            wr_data,
  input  logic [3:0]             wr_strb,
  input  logic [3:0]             rd_addr,
  input  logic                   rd_en,
  output logic [31:0]            rd_data,
  input  logic [SENSOR_BITS-1:0] sensor_in,
  output logic                   irq
);

  localparam int LW = clog2(SENSOR_BITS + 1);
  localparam logic [LW-1:0] NMAX = LW'(SENSOR_BITS);

  logic [SENSOR_BITS-1:0] stable, stable_inc;
  logic                   stable_valid;

  fli_sample_debounce #(
    .SENSOR_BITS(SENSOR_BITS),
    .CLK_DIV    (CLK_DIV),
    .DEBOUNCE   (DEBOUNCE)
  ) u_sd (
    .clk         (clk),
    .rst         (rst),
    .sensor_in   (sensor_in),
    .stable      (stable),
    .stable_valid(stable_valid)
  );

  logic [LW-1:0]      level_q, level_d, hi_q, hi_d, lo_q, lo_d;
  logic               err_q, err_d;
  logic [NUM_EVT-1:0] ier_q, ier_d, ifr_q, ifr_d, hist_q, cond, rise, ifr_clr;
  logic               wr_ok;
  logic [1:0]         wa;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{wr_addr[1:0], rd_addr[1:0], wr_data};

  function automatic logic [LW-1:0] sat(input logic [LW-1:0] v);
    return (v > NMAX) ? NMAX : v;
  endfunction

  // A valid thermometer code plus one has no bits in common with itself.
  assign stable_inc = stable + SENSOR_BITS'(1);
  assign err_d      = |(stable & stable_inc);

  always_comb begin
    level_d = '0;
    for (int k = 0; k < SENSOR_BITS; k++)
      if (stable[k]) level_d = LW'(k + 1);
  end

  always_comb begin
    cond            = '0;
    cond[EVT_FULL]  = (level_q == NMAX);
    cond[EVT_EMPTY] = (level_q == '0);
    cond[EVT_ERROR] = err_q;
    cond[EVT_HIGH]  = (level_q >= hi_q);
    cond[EVT_LOW]   = (level_q <= lo_q);
  end

  assign rise  = cond & ~hist_q;
  assign wr_ok = wr_en && (wr_strb == 4'hF);
  assign wa    = wr_addr[3:2];

  always_comb begin
    ier_d   = ier_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    ifr_clr = '0;
    if (wr_ok) begin
      case (wa)
        REG_IER: ier_d   = wr_data[NUM_EVT-1:0];
        REG_IFR: ifr_clr = wr_data[NUM_EVT-1:0];
        REG_THR: begin
          lo_d = sat(wr_data[LW-1:0]);
          hi_d = sat(wr_data[16 +: LW]);
        end
        default: ;
      endcase
    end
    // A fresh event outranks a same-cycle clear.
    ifr_d = (ifr_q & ~ifr_clr) | rise;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= '0;
      err_q   <= 1'b0;
      ier_q   <= '0;
      ifr_q   <= '0;
      hi_q    <= NMAX;
      lo_q    <= '0;
      hist_q  <= '1;
    end else begin
      level_q <= level_d;
      err_q   <= err_d;
      ier_q   <= ier_d;
      ifr_q   <= ifr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hist_q  <= cond;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      case (rd_addr[3:2])
        REG_LVL: begin
          rd_data[LW-1:0] = level_q;
          rd_data[30]     = stable_valid;
          rd_data[31]     = err_q;
        end
        REG_IER: rd_data[NUM_EVT-1:0] = ier_q;
        REG_IFR: rd_data[NUM_EVT-1:0] = ifr_q;
        REG_THR: begin
          rd_data[LW-1:0]  = lo_q;
          rd_data[16 +: LW] = hi_q;
        end
        default: ;
      endcase
    end
  end

  assign irq = |(ier_q & ifr_q);

endmodule

// File: tb/tb_fluid_level_monitor.sv
// Directed bench: stimulus pushes expected read/irq values into a queue, a
// negedge monitor pops and compares whenever a read or irq probe is presented.
module tb_fluid_level_monitor;

  localparam int N  = 8;
  localparam int CD = 9;
  localparam int DB = 3;

  localparam logic [3:0] A_LVL = 4'h0;
  localparam logic [3:0] A_IER = 4'h4;
  localparam logic [3:0] A_IFR = 4'h8;
  localparam logic [3:0] A_THR = 4'hC;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   wr_addr = '0;
  logic         wr_en = 1'b0;
  logic [31:0]  wr_data = '0;
  logic [3:0]   wr_strb = '0;
  logic [3:0]   rd_addr = '0;
  logic         rd_en = 1'b0;
  logic [31:0]  rd_data;
  logic [N-1:0] sensor_in = '0;
  logic         irq;
  logic         irq_chk = 1'b0;

  always #5 clk = ~clk;

  fluid_level_monitor #(.SENSOR_BITS(N), .CLK_DIV(CD), .DEBOUNCE(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_addr  (wr_addr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb),
    .rd_addr  (rd_addr),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .sensor_in(sensor_in),
    .irq      (irq)
  );

  // Reference tick timing: one tick cycle every CD+1 clocks after reset.
  int   mcnt;
  logic mtick;
  always @(posedge clk or negedge rst)
    if (!rst) mcnt <= CD;
    else      mcnt <= (mcnt == 0) ? CD : mcnt - 1;
  assign mtick = (mcnt == 0);

  typedef struct {
    logic        is_irq;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      if (rd_en || irq_chk) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty got output with no expectation");
        end else begin
          c   = q.pop_front();
          act = c.is_irq ? {31'b0, irq} : rd_data;
          if (act !== c.exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", c.name, act, c.exp);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string n);
    chk_t c;
    c.is_irq = 1'b0; c.exp = e; c.name = n;
    q.push_back(c);
    rd_addr = a;
    rd_en   = 1'b1;
    step();
    rd_en   = 1'b0;
  endtask

  task automatic chk_irq(input logic e, input string n);
    chk_t c;
    c.is_irq = 1'b1; c.exp = {31'b0, e}; c.name = n;
    q.push_back(c);
    irq_chk = 1'b1;
    step();
    irq_chk = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_addr = a; wr_data = d; wr_strb = s; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  // Returns in the cycle right after the n-th tick cycle.
  task automatic wait_tick(input int n);
    repeat (n) begin
      while (!mtick) step();
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  initial begin
    step(); step();
    rd(A_LVL, 32'h0, "rst_lvl");
    rd(A_THR, 32'h0008_0000, "rst_thr");
    rd(A_IER, 32'h0, "rst_ier");
    rd(A_IFR, 32'h0, "rst_ifr");
    chk_irq(1'b0, "rst_irq");
    rst = 1'b1;

    wait_tick(2);
    rd(A_LVL, 32'h0, "pre_valid_lvl");
    wait_tick(1);
    rd(A_LVL, 32'h4000_0000, "valid_lvl");
    step();
    rd(A_IFR, 32'h0, "empty_no_fire");

    // Ramp with HI=6 LO=2 and all events enabled.
    wr(A_IER, 32'h1F, 4'hF);
    wr(A_THR, 32'h0006_0002, 4'hF);
    rd(A_THR, 32'h0006_0002, "thr_rw");
    for (int k = 1; k <= N; k++) begin
      sensor_in = N'((1 << k) - 1);
      wait_tick(5);
      if (k == 6) begin
        rd(A_IFR, 32'h08, "ifr_high");
        chk_irq(1'b1, "irq_high");
      end
    end
    rd(A_LVL, 32'h4000_0008, "full_lvl");
    rd(A_IFR, 32'h09, "ifr_full");
    chk_irq(1'b1, "irq_full");

    wr(A_IFR, 32'h09, 4'h3);
    rd(A_IFR, 32'h09, "ifr_partial_strb");
    wr(A_IFR, 32'h09, 4'hF);
    chk_irq(1'b0, "irq_drop");
    rd(A_IFR, 32'h0, "ifr_cleared");

    // Glitch shorter than the debounce window is rejected.
    sensor_in = 8'h07;
    wait_tick(5);
    rd(A_LVL, 32'h4000_0003, "lvl3");
    sensor_in = 8'h0F;
    wait_tick(2);
    sensor_in = 8'h07;
    wait_tick(3);
    rd(A_LVL, 32'h4000_0003, "glitch_lvl");
    rd(A_IFR, 32'h0, "glitch_ifr");
    sensor_in = 8'h0F;
    wait_tick(3);
    rd(A_LVL, 32'h4000_0003, "lvl4_t1");
    rd(A_LVL, 32'h4000_0004, "lvl4_t2");

    // Non-thermometer pattern raises ERROR.
    sensor_in = 8'h05;
    wait_tick(3);
    rd(A_LVL, 32'h4000_0004, "err_t1");
    rd(A_LVL, 32'hC000_0003, "err_lvl");
    rd(A_IFR, 32'h04, "err_ifr");
    chk_irq(1'b1, "irq_err");
    wr(A_IFR, 32'h04, 4'hF);
    rd(A_IFR, 32'h0, "err_clr");
    sensor_in = 8'h07;
    wait_tick(3);
    step(); step();
    sensor_in = 8'h05;
    wait_tick(3);
    step();
    wr(A_IFR, 32'h04, 4'hF);
    rd(A_IFR, 32'h04, "set_beats_clear");
    wr(A_IFR, 32'h04, 4'hF);
    rd(A_IFR, 32'h0, "ifr_clr2");

    // Threshold writes that are immediately true fire once.
    wr(A_THR, 32'h0003_0000, 4'hF);
    rd(A_IFR, 32'h0, "thr_c1");
    rd(A_IFR, 32'h08, "thr_high_fire");
    wr(A_THR, 32'h000F_000F, 4'hF);
    rd(A_THR, 32'h0008_0008, "thr_sat");
    rd(A_IFR, 32'h18, "low_fire");

    wr(A_IER, 32'h0, 4'hF);
    chk_irq(1'b0, "irq_ier0");
    wr(A_IER, 32'h10, 4'hF);
    chk_irq(1'b1, "irq_ier_en");
    rd(A_IER, 32'h10, "ier_rd");

    // Asynchronous reset in the middle of a debounce run.
    sensor_in = 8'h07;
    wait_tick(2);
    rst = 1'b0;
    rd(A_LVL, 32'h0, "arst_lvl");
    chk_irq(1'b0, "arst_irq");
    rd(A_IFR, 32'h0, "arst_ifr");
    rd(A_IER, 32'h0, "arst_ier");
    rd(A_THR, 32'h0008_0000, "arst_thr");
    rst = 1'b1;
    wait_tick(2);
    rd(A_LVL, 32'h0, "rel_pre");
    wait_tick(1);
    rd(A_LVL, 32'h4000_0000, "rel_valid");
    rd(A_LVL, 32'h4000_0003, "rel_lvl");
    rd(A_IFR, 32'h0, "rel_ifr");

    step(); step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_checks got %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fluid_level_monitor.md
Name: fluid_level_monitor

Overview:
- Parametrised multi-sensor tank level peripheral on the MicroBlaze AXI4-Lite register bridge.
- Samples a `SENSOR_BITS`-wide thermometer sensor bus on a programmable tick and debounces it over `DEBOUNCE` consecutive ticks.
- Derives the level and a consistency error from the debounced value.
- Raises maskable interrupts for FULL, EMPTY, ERROR and two software-programmable threshold crossings (HIGH/LOW).

Parameters:
- `SENSOR_BITS`, 8, number of level sensors N (2..15); level range 0..N.
- `CLK_DIV`, 9999999, tick reload value; one tick every `CLK_DIV+1` clocks (`CLK_DIV=0` gives a tick every cycle).
- `DEBOUNCE`, 3, consecutive identical tick samples required before acceptance (1..15; 1 means no filtering).
- `LW`, derived, `clog2(SENSOR_BITS+1)`; level width (4 for N=8).

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  asynchronous active-low reset.
- `wr_addr`  in  4  register write address (byte).
- `wr_en`  in  1  write strobe.
- `wr_data`  in  32  write data.
- `wr_strb`  in  4  byte enables; a write takes effect only when 4'hF.
- `rd_addr`  in  4  register read address.
- `rd_en`  in  1  read strobe.
- `rd_data`  out  32  read data, combinational.
- `sensor_in`  in  SENSOR_BITS  raw sensor inputs; bit k = fluid above sensor k.
- `irq`  out  1  interrupt request, level, active high.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - tick counter <= `CLK_DIV`; candidate, stable and debounce count <= 0.
  - level <= 0; error <= 0; IER <= 0; IFR <= 0; THR <= {HI=N, LO=0}.
  - All event-history registers <= 1, so no event fires until its condition first goes false and then true.
  - `irq`=0. `rd_data` follows `rd_en`; it is 0 while `rd_en`=0.
- Tick: counter decrements each clock; at 0 it asserts tick for one cycle and reloads `CLK_DIV`.
- Debounce, evaluated on tick only:
  - If `sensor_in` differs from the candidate: candidate <= `sensor_in`, cnt <= 1.
  - Otherwise cnt saturates at `DEBOUNCE`.
  - When the sample taken at tick T makes cnt reach `DEBOUNCE`, stable <= candidate at T+1.
- Level, registered one cycle after stable (T+2): index+1 of the highest set stable bit, 0 if none.
- Error, registered at T+2: 1 unless stable is of the form 0..01..1 (including all-zero and all-one).
- Event conditions, rising-edge detected over 2-sample history, IFR bit set at T+3:
  - bit0 FULL: level==N.
  - bit1 EMPTY: level==0.
  - bit2 ERROR: error.
  - bit3 HIGH: level>=HI.
  - bit4 LOW: level<=LO.
- Registers. Offsets are byte addresses; decode uses `addr[3:2]`.
  - 0x00 LVL (RO): [LW-1:0] level, [30] stable_valid (1 once the first debounced value is accepted after reset), [31] error; other bits 0.
  - 0x04 IER (R/W): [4:0] enables; upper bits read 0.
  - 0x08 IFR (R/W1C): [4:0]; writing 1 clears a bit. Set has priority over clear when both occur in the same cycle.
  - 0x0C THR (R/W): [LW-1:0] LO, [LW+15:16] HI.
    - Written values above N saturate to N.
    - If LO>=HI both are still stored; HIGH and LOW may then fire together.
- Writes with `wr_strb`!=4'hF, or to RO/unused bits, are ignored.
- `irq` = OR of (IER & IFR), combinational from the registers; no extra latency.
- Enabling IER for an already-set IFR bit asserts `irq` the cycle after the write.
- Simultaneous level change and IFR write in one cycle: set wins, bit stays 1.
- Threshold write: the new threshold takes effect the next cycle. An immediately true HIGH/LOW condition fires only if the history held 0; the history updates every cycle, so a level already past the new threshold does fire once.

Decomposition:
- Package `fli_pkg` holds:
  - register offsets (LVL=0, IER=1, IFR=2, THR=3 word index);
  - event bit indices (FULL=0, EMPTY=1, ERROR=2, HIGH=3, LOW=4);
  - `NUM_EVT=5`;
  - a `clog2` constant function for `LW`.
- One sub-module, `fli_sample_debounce`: tick generator plus candidate/count/stable logic. Parameters `SENSOR_BITS`, `CLK_DIV`, `DEBOUNCE`; outputs `stable` and `stable_valid`.

Test Plan (`SENSOR_BITS`=8, `CLK_DIV`=9, `DEBOUNCE`=3):
- Reset release with `sensor_in`=0x00 -> LVL reads 0x4000_0000 after 3 ticks. IFR stays 0, since EMPTY history was reset to 1.
- Ramp 0x00→0x01→…→0xFF, each held 5 ticks, IER=0x1F, THR HI=6 LO=2 -> HIGH set when level reaches 6 and FULL at 8; `irq`=1. LVL=0x4000_0008.
- Write IFR=0x09 with `wr_strb`=4'hF -> IFR bits 0,3 clear and `irq` drops the next cycle. Repeat with `wr_strb`=4'h3 -> no change.
- Glitch: `sensor_in` 0x0F for 2 ticks inside a stable 0x07 period -> level stays 3, no event. Hold 0x0F for 3 ticks -> level 4 exactly 2 cycles after the third tick.
- `sensor_in`=0x05 for 3 ticks -> LVL bit31=1, level=3, IFR bit2 set. Clear in the same cycle as a new ERROR edge -> bit2 remains 1.
- Assert `rst`=0 mid-debounce (cnt=2) -> all registers reset immediately, asynchronously, and `irq`=0. After release, 3 fresh ticks are needed before stable_valid=1.
